// File: rtl/event_counter_bank_if.sv
// Read-port handshake bundle for event_counter_bank.
// master: requester; slave: the counter bank.
interface event_counter_bank_if #(
  parameter int IDX_W     = 4,
  parameter int CNT_WIDTH = 32
);
  logic                 rd_req_valid;
  logic                 rd_req_ready;
  logic [IDX_W-1:0]     rd_req_idx;
  logic                 rd_req_snap;
  logic                 rd_resp_valid;
  logic                 rd_resp_ready;
  logic [CNT_WIDTH-1:0] rd_resp_data;
  logic                 rd_resp_err;

  modport master (
    output rd_req_valid, rd_req_idx, rd_req_snap,
    output rd_resp_ready,
    input  rd_req_ready, rd_resp_valid,
    input  rd_resp_data, rd_resp_err
  );

  modport slave (
    input  rd_req_valid, rd_req_idx, rd_req_snap,
    input  rd_resp_ready,
    output rd_req_ready, rd_resp_valid,
    output rd_resp_data, rd_resp_err
  );
endinterface

// File: rtl/event_counter_bank.sv
// Bank of saturating event counters with windowed snapshots.
// Ports: clk, rst (async low), evt_inc/evt_mask, freeze, clear,
//   rd (read handshake), cycle_count, snap_pulse, overflow.
module event_counter_bank #(
  parameter int NUM_EVENTS    = 16,
  parameter int CNT_WIDTH     = 32,
  parameter int INC_WIDTH     = 2,
  parameter int WINDOW_CYCLES = 0,
  localparam int IDX_W = (NUM_EVENTS > 1) ?
                         $clog2(NUM_EVENTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_EVENTS*INC_WIDTH-1:0] evt_inc,
  input  logic [NUM_EVENTS-1:0]           evt_mask,
  input  logic                            freeze,
  input  logic                            clear,
  event_counter_bank_if.slave             rd,
  output logic [CNT_WIDTH-1:0]            cycle_count,
  output logic                            snap_pulse,
  output logic [NUM_EVENTS-1:0]           overflow
);
  localparam int SW = CNT_WIDTH + 1;
  localparam int WIN_W = (WINDOW_CYCLES > 1) ?
                         $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] POS_LAST =
    WIN_W'((WINDOW_CYCLES > 0) ? WINDOW_CYCLES - 1 : 0);

  typedef enum logic {S_IDLE, S_RESP} rd_state_e;

  logic [CNT_WIDTH-1:0]  live_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  live_d [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  snap_q [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  snap_d [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]  cyc_q, cyc_d;
  logic [WIN_W-1:0]      pos_q, pos_d;
  logic                  pulse_q, pulse_d;

  logic                  win_end, adv;
  logic [INC_WIDTH-1:0]  inc;
  logic [SW-1:0]         sum;
  logic [CNT_WIDTH-1:0]  sat_v;

  rd_state_e             st_q;
  logic                  rdy_q, rv_q, err_q;
  logic [CNT_WIDTH-1:0]  data_q;
  logic [CNT_WIDTH-1:0]  rd_sel;
  logic                  rd_oor;

  always_comb begin
    win_end = 1'b0;
    if (WINDOW_CYCLES > 0)
      win_end = (pos_q == POS_LAST);
    adv     = !freeze && !clear;
    pulse_d = adv && win_end;
    cyc_d   = cyc_q;
    pos_d   = pos_q;
    ovf_d   = ovf_q;
    inc     = '0;
    sum     = '0;
    sat_v   = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      live_d[i] = live_q[i];
      snap_d[i] = snap_q[i];
      inc = evt_mask[i] ?
            evt_inc[i*INC_WIDTH +: INC_WIDTH] : '0;
      // extra carry bit detects saturation
      sum   = {1'b0, live_q[i]} + SW'(inc);
      sat_v = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
      if (clear) begin
        live_d[i] = '0;
        ovf_d[i]  = 1'b0;
      end else if (adv) begin
        ovf_d[i] = ovf_q[i] | sum[CNT_WIDTH];
        if (win_end) begin
          snap_d[i] = sat_v;
          live_d[i] = '0;
        end else begin
          live_d[i] = sat_v;
        end
      end
    end
    if (clear) begin
      cyc_d = '0;
      pos_d = '0;
    end else if (adv) begin
      cyc_d = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
      if (WINDOW_CYCLES > 0)
        pos_d = win_end ? '0 : pos_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
      ovf_q   <= '0;
      cyc_q   <= '0;
      pos_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        live_q[i] <= live_d[i];
        snap_q[i] <= snap_d[i];
      end
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      pos_q   <= pos_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    rd_sel = '0;
    rd_oor = 1'b1;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (32'(rd.rd_req_idx) == i) begin
        rd_oor = 1'b0;
        rd_sel = rd.rd_req_snap ? snap_q[i] : live_q[i];
      end
    end
  end

  // ready is registered so it stays low through reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      rdy_q  <= 1'b0;
      rv_q   <= 1'b0;
      err_q  <= 1'b0;
      data_q <= '0;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          rdy_q <= 1'b1;
          if (rd.rd_req_valid && rdy_q) begin
            st_q   <= S_RESP;
            rdy_q  <= 1'b0;
            rv_q   <= 1'b1;
            data_q <= rd_sel;
            err_q  <= rd_oor;
          end
        end
        S_RESP: begin
          if (rd.rd_resp_ready) begin
            st_q  <= S_IDLE;
            rdy_q <= 1'b1;
            rv_q  <= 1'b0;
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign rd.rd_req_ready  = rdy_q;
  assign rd.rd_resp_valid = rv_q;
  assign rd.rd_resp_data  = data_q;
  assign rd.rd_resp_err   = err_q;
  assign cycle_count      = cyc_q;
  assign snap_pulse       = pulse_q;
  assign overflow         = ovf_q;
endmodule
